// File: rtl/syn_sram_arb_pkg.sv
// Purpose : shared types, constants and strobe decode for the SRAM arbiter slice.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
package syn_sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_BE_W   = 2;
  localparam int SRAM_WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    END  = 2'd2
  } sram_arb_fsm_t;

  // Pin strobes grouped so they can be computed and registered as one word.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
    logic dq_oe;
  } sram_strb_t;

  localparam sram_strb_t STRB_IDLE = '{
    ce_n:  1'b1,
    oe_n:  1'b1,
    we_n:  1'b1,
    lb_n:  1'b1,
    ub_n:  1'b1,
    dq_oe: 1'b0
  };

  // Strobe pattern for a given FSM state and access type.
  // END keeps ce_n, byte lanes and the pad drive for hold time but releases
  // oe_n/we_n. The pad is only driven on writes, and oe_n is only low on reads,
  // so the two can never overlap.
  function automatic sram_strb_t strb_decode(input sram_arb_fsm_t       st,
                                             input logic                wr,
                                             input logic [SRAM_BE_W-1:0] be);
    sram_strb_t s;
    s = STRB_IDLE;
    case (st)
      ACC: begin
        s.ce_n  = 1'b0;
        s.oe_n  = wr;
        s.we_n  = ~wr;
        s.lb_n  = ~be[0];
        s.ub_n  = ~be[1];
        s.dq_oe = wr;
      end
      END: begin
        s.ce_n  = 1'b0;
        s.lb_n  = ~be[0];
        s.ub_n  = ~be[1];
        s.dq_oe = wr;
      end
      default: s = STRB_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/syn_sram_arb_rr_arb.sv
// Purpose : round-robin pick among agents 1..P_NUM_AGENTS-1 plus its pointer register.
// Latency : grant is combinational from req/pointer; pointer updates on the edge where adv is set.
// Backpr. : none; the caller decides when a pick is consumed by asserting adv.
// Ports   : clk_ir/rst_ih clock and sync active-high reset; req request vector
//           (agent 0 excluded); adv consume the current pick; gnt one-hot pick.
module syn_rr_arb #(
  parameter int P_NUM_AGENTS = 3
) (
  input  logic                    clk_ir,
  input  logic                    rst_ih,
  input  logic [P_NUM_AGENTS-1:1] req,
  input  logic                    adv,
  output logic [P_NUM_AGENTS-1:1] gnt
);

  localparam int PTR_W = $clog2(P_NUM_AGENTS);

  logic [PTR_W-1:0] ptr_q;
  logic             found;

  // First pass: lowest requester at or above the pointer. Second pass: wrap
  // around to the lowest requester overall.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i < P_NUM_AGENTS; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 1; i < P_NUM_AGENTS; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1, wrapping back to agent 1.
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      ptr_q <= PTR_W'(1);
    end else if (adv && found) begin
      for (int i = 1; i < P_NUM_AGENTS; i++) begin
        if (gnt[i]) begin
          ptr_q <= (i == P_NUM_AGENTS - 1) ? PTR_W'(1) : PTR_W'(i + 1);
        end
      end
    end
  end

endmodule

// File: rtl/syn_sram_arb.sv
// Purpose : arbitrates agent word requests onto one async 256K x 16 SRAM with a fixed access cycle.
// Latency : gnt one cycle after the request is sampled; rd_valid 2+P_ACC_WAIT cycles after that sample.
// Backpr. : agents hold req/addr/data until the one-cycle gnt pulse; one access per 2+P_ACC_WAIT cycles.
// Ports   : clk_ir/rst_ih clock and sync active-high reset; agent_* packed per-agent
//           request side (req, wr, addr, wdata, be) with gnt/rd_valid one-hot pulses and
//           shared rd_data; sram_* pad side (addr, dq_o/dq_oe/dq_i, active-low strobes).
// Config  : define SYN_SRAM_ARB_RR_EN for round-robin among agents 1..N-1; default is
//           fixed priority. Agent 0 always wins when requesting.
module syn_sram_arb
  import syn_sram_arb_pkg::*;
#(
  parameter int P_NUM_AGENTS = 3,
  parameter int P_DATA_W     = SRAM_DATA_W,
  parameter int P_ADDR_W     = SRAM_ADDR_W,
  parameter int P_ACC_WAIT   = 1
) (
  input  logic                             clk_ir,
  input  logic                             rst_ih,
  input  logic [P_NUM_AGENTS-1:0]          agent_req,
  input  logic [P_NUM_AGENTS-1:0]          agent_wr,
  input  logic [P_NUM_AGENTS*P_ADDR_W-1:0] agent_addr,
  input  logic [P_NUM_AGENTS*P_DATA_W-1:0] agent_wdata,
  input  logic [P_NUM_AGENTS*2-1:0]        agent_be,
  output logic [P_NUM_AGENTS-1:0]          agent_gnt,
  output logic [P_NUM_AGENTS-1:0]          agent_rd_valid,
  output logic [P_DATA_W-1:0]              rd_data,
  output logic [P_ADDR_W-1:0]              sram_addr,
  output logic [P_DATA_W-1:0]              sram_dq_o,
  output logic                             sram_dq_oe,
  input  logic [P_DATA_W-1:0]              sram_dq_i,
  output logic                             sram_ce_n,
  output logic                             sram_oe_n,
  output logic                             sram_we_n,
  output logic                             sram_lb_n,
  output logic                             sram_ub_n
);

  localparam logic [SRAM_WAIT_W-1:0] ACC_LAST = SRAM_WAIT_W'(P_ACC_WAIT);

  sram_arb_fsm_t state_q, state_d;
  logic [SRAM_WAIT_W-1:0] wait_q, wait_d;

  logic                    any_req;
  logic                    arb_en;
  logic                    acc_done;
  logic [P_NUM_AGENTS-1:0] win_oh;

  // Winner's request fields, muxed from the packed agent buses.
  logic                    sel_wr;
  logic [P_ADDR_W-1:0]     sel_addr;
  logic [P_DATA_W-1:0]     sel_wdata;
  logic [1:0]              sel_be;

  // Registered copy of the accepted request; owns the pads for the access.
  logic                    wr_q;
  logic [P_ADDR_W-1:0]     addr_q;
  logic [P_DATA_W-1:0]     wdata_q;
  logic [1:0]              be_q;
  logic [P_NUM_AGENTS-1:0] own_q;

  logic                    wr_nxt;
  logic [1:0]              be_nxt;
  sram_strb_t              strb_d, strb_q;
  logic [P_NUM_AGENTS-1:0] gnt_d;
  logic [P_NUM_AGENTS-1:0] rdv_d;

  assign any_req  = |agent_req;
  // END arbitrates exactly like IDLE so pending work goes straight back to ACC.
  assign arb_en   = ((state_q == IDLE) || (state_q == END)) && any_req;
  assign acc_done = (state_q == ACC) && (wait_q == ACC_LAST);

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef SYN_SRAM_ARB_RR_EN
  logic [P_NUM_AGENTS-1:1] rr_gnt;
  logic                    rr_adv;

  // Pointer only advances when a non-zero agent actually takes the grant.
  assign rr_adv = arb_en && !agent_req[0];

  syn_rr_arb #(
    .P_NUM_AGENTS(P_NUM_AGENTS)
  ) u_rr_arb (
    .clk_ir (clk_ir),
    .rst_ih (rst_ih),
    .req    (agent_req[P_NUM_AGENTS-1:1]),
    .adv    (rr_adv),
    .gnt    (rr_gnt)
  );

  always_comb begin
    if (agent_req[0]) begin
      win_oh = P_NUM_AGENTS'(1);
    end else begin
      win_oh = {rr_gnt, 1'b0};
    end
  end
`else
  logic fp_found;

  // Lowest requesting index wins; agent 0 naturally first.
  always_comb begin
    win_oh   = '0;
    fp_found = 1'b0;
    for (int i = 0; i < P_NUM_AGENTS; i++) begin
      if (!fp_found && agent_req[i]) begin
        win_oh[i] = 1'b1;
        fp_found  = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < P_NUM_AGENTS; i++) begin
      if (win_oh[i]) begin
        sel_wr    = agent_wr[i];
        sel_addr  = agent_addr[i*P_ADDR_W +: P_ADDR_W];
        sel_wdata = agent_wdata[i*P_DATA_W +: P_DATA_W];
        sel_be    = agent_be[i*2 +: 2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACC;
          wait_d  = '0;
        end
      end
      ACC: begin
        if (wait_q == ACC_LAST) begin
          state_d = END;
        end else begin
          wait_d = wait_q + SRAM_WAIT_W'(1);
        end
      end
      END: begin
        if (any_req) begin
          state_d = ACC;
          wait_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Strobes are decoded from the next state and registered so
  // the SRAM pins come straight off flops and never glitch.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_nxt = arb_en ? sel_wr : wr_q;
    be_nxt = arb_en ? sel_be : be_q;
    strb_d = strb_decode(state_d, wr_nxt, be_nxt);
    gnt_d  = arb_en ? win_oh : '0;
    rdv_d  = (acc_done && !wr_q) ? own_q : '0;
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      strb_q         <= STRB_IDLE;
      agent_gnt      <= '0;
      agent_rd_valid <= '0;
      rd_data        <= '0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      own_q          <= '0;
    end else begin
      strb_q         <= strb_d;
      agent_gnt      <= gnt_d;
      agent_rd_valid <= rdv_d;
      if (arb_en) begin
        wr_q    <= sel_wr;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
        own_q   <= win_oh;
      end
      // Pad data sampled on the edge that closes the last ACC cycle.
      if (acc_done && !wr_q) begin
        rd_data <= sram_dq_i;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_ce_n  = strb_q.ce_n;
  assign sram_oe_n  = strb_q.oe_n;
  assign sram_we_n  = strb_q.we_n;
  assign sram_lb_n  = strb_q.lb_n;
  assign sram_ub_n  = strb_q.ub_n;
  assign sram_dq_oe = strb_q.dq_oe;

endmodule

// File: tb/tb_syn_sram_arb.sv
// Purpose : directed self-checking bench for syn_sram_arb with a behavioural async SRAM.
// Latency : n/a.
// Backpr. : n/a.
module tb_syn_sram_arb;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 18;

  logic            clk_ir = 1'b0;
  logic            rst_ih;
  logic [N-1:0]    agent_req;
  logic [N-1:0]    agent_wr;
  logic [N*AW-1:0] agent_addr;
  logic [N*DW-1:0] agent_wdata;
  logic [N*2-1:0]  agent_be;
  logic [N-1:0]    agent_gnt;
  logic [N-1:0]    agent_rd_valid;
  logic [DW-1:0]   rd_data;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_dq_o;
  logic            sram_dq_oe;
  logic [DW-1:0]   sram_dq_i;
  logic            sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int contention = 0;
  int oe_low     = 0;

  logic [15:0] mem [0:262143];

  syn_sram_arb #(
    .P_NUM_AGENTS(N),
    .P_DATA_W    (DW),
    .P_ADDR_W    (AW),
    .P_ACC_WAIT  (1)
  ) dut (
    .clk_ir        (clk_ir),
    .rst_ih        (rst_ih),
    .agent_req     (agent_req),
    .agent_wr      (agent_wr),
    .agent_addr    (agent_addr),
    .agent_wdata   (agent_wdata),
    .agent_be      (agent_be),
    .agent_gnt     (agent_gnt),
    .agent_rd_valid(agent_rd_valid),
    .rd_data       (rd_data),
    .sram_addr     (sram_addr),
    .sram_dq_o     (sram_dq_o),
    .sram_dq_oe    (sram_dq_oe),
    .sram_dq_i     (sram_dq_i),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_lb_n     (sram_lb_n),
    .sram_ub_n     (sram_ub_n)
  );

  always #5 clk_ir = ~clk_ir;

  always @(posedge clk_ir) cyc <= cyc + 1;

  // Async SRAM: reads drive the bus while selected, writes latch on we_n rising.
  assign sram_dq_i = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0) begin
      if (sram_lb_n === 1'b0) mem[sram_addr][7:0]  = sram_dq_o[7:0];
      if (sram_ub_n === 1'b0) mem[sram_addr][15:8] = sram_dq_o[15:8];
    end
  end

  always @(negedge clk_ir) begin
    if (sram_oe_n === 1'b0 && sram_dq_oe === 1'b1) contention = contention + 1;
    if (sram_oe_n === 1'b0) oe_low = oe_low + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic set_agent(input int i, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input logic [1:0] be);
    agent_wr[i]                = wr;
    agent_addr[i*AW +: AW]     = addr;
    agent_wdata[i*DW +: DW]    = wd;
    agent_be[i*2 +: 2]         = be;
  endtask

  // Returns idx=-1 if no grant shows up inside the budget.
  task automatic wait_gnt(output int idx, output int at);
    idx = -1;
    at  = -1;
    for (int k = 0; k < 20 && idx < 0; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (agent_gnt[i]) begin
          idx = i;
          at  = cyc;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_ih      = 1'b1;
    agent_req   = '0;
    agent_wr    = '0;
    agent_addr  = '0;
    agent_wdata = '0;
    agent_be    = '0;
    tick();
    tick();
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 11111",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
    end
    n_checks++;
    if ({sram_dq_oe, agent_gnt, agent_rd_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_oe_gnt_rdv: got %b expected 0", {sram_dq_oe, agent_gnt, agent_rd_valid});
    end
    n_checks++;
    if ({sram_addr, sram_dq_o, rd_data} !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h %h %h expected 0", sram_addr, sram_dq_o, rd_data);
    end
    rst_ih = 1'b0;
    tick();
    n_checks++;
    if (sram_ce_n !== 1'b1 || agent_gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got ce_n=%b gnt=%b expected 1 000", sram_ce_n, agent_gnt);
    end
  endtask

  task automatic test_single_read();
    int idx, at, r0;
    mem[18'h00010] = 16'hBEEF;
    set_agent(1, 1'b0, 18'h00010, 16'h0, 2'b11);
    agent_req[1] = 1'b1;
    r0 = cyc;
    wait_gnt(idx, at);
    agent_req[1] = 1'b0;
    n_checks++;
    if (idx !== 1 || at !== r0 + 1) begin
      n_fail++;
      $display("FAIL rd_gnt: got agent %0d at +%0d expected agent 1 at +1", idx, at - r0);
    end
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n} !== 6'b001000 ||
        sram_addr !== 18'h00010) begin
      n_fail++;
      $display("FAIL rd_acc1: got strb=%b addr=%h expected 001000 00010",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n}, sram_addr);
    end
    tick();
    n_checks++;
    if (sram_oe_n !== 1'b0 || agent_rd_valid !== 3'b000 || agent_gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_acc2: got oe_n=%b rdv=%b gnt=%b expected 0 000 000",
               sram_oe_n, agent_rd_valid, agent_gnt);
    end
    tick();
    n_checks++;
    if (sram_oe_n !== 1'b1 || sram_ce_n !== 1'b0 || agent_rd_valid !== 3'b010 || rd_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_end: got oe_n=%b ce_n=%b rdv=%b data=%h expected 1 0 010 beef",
               sram_oe_n, sram_ce_n, agent_rd_valid, rd_data);
    end
    tick();
    n_checks++;
    if (sram_ce_n !== 1'b1 || agent_rd_valid !== 3'b000 || rd_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_idle: got ce_n=%b rdv=%b data=%h expected 1 000 beef",
               sram_ce_n, agent_rd_valid, rd_data);
    end
  endtask

  task automatic test_byte_write();
    int idx, at;
    mem[18'h3FFFF] = 16'hABCD;
    set_agent(2, 1'b1, 18'h3FFFF, 16'h1234, 2'b10);
    agent_req[2] = 1'b1;
    wait_gnt(idx, at);
    agent_req[2] = 1'b0;
    n_checks++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL wr_gnt: got %0d expected 2", idx);
    end
    n_checks++;
    if ({sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b01011 ||
        sram_dq_o !== 16'h1234 || sram_addr !== 18'h3FFFF) begin
      n_fail++;
      $display("FAIL wr_acc1: got strb=%b dq=%h addr=%h expected 01011 1234 3ffff",
               {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dq_oe}, sram_dq_o, sram_addr);
    end
    tick();
    n_checks++;
    if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_acc2: got we_n=%b dq_oe=%b expected 0 1", sram_we_n, sram_dq_oe);
    end
    tick();
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b1 || sram_ce_n !== 1'b0 || sram_dq_o !== 16'h1234) begin
      n_fail++;
      $display("FAIL wr_end_hold: got we_n=%b dq_oe=%b ce_n=%b dq=%h expected 1 1 0 1234",
               sram_we_n, sram_dq_oe, sram_ce_n, sram_dq_o);
    end
    tick();
    n_checks++;
    if (sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1 || {sram_ub_n, sram_lb_n} !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_idle: got dq_oe=%b ce_n=%b ub/lb=%b expected 0 1 11",
               sram_dq_oe, sram_ce_n, {sram_ub_n, sram_lb_n});
    end
    n_checks++;
    if (mem[18'h3FFFF] !== 16'h12CD) begin
      n_fail++;
      $display("FAIL wr_mem_bytes: got %h expected 12cd", mem[18'h3FFFF]);
    end
  endtask

  task automatic test_priority();
    int idx, at, prev;
    int exp_ord [3] = '{0, 1, 2};
    mem[18'h00100] = 16'h1000;
    mem[18'h00101] = 16'h1001;
    mem[18'h00102] = 16'h1002;
    for (int i = 0; i < N; i++) set_agent(i, 1'b0, AW'(18'h00100 + i), 16'h0, 2'b11);
    agent_req = 3'b111;
    prev = 0;
    for (int g = 0; g < 3; g++) begin
      wait_gnt(idx, at);
      if (idx >= 0) agent_req[idx] = 1'b0;
      n_checks++;
      if (idx !== exp_ord[g] || (g > 0 && at - prev !== 3)) begin
        n_fail++;
        $display("FAIL prio_order%0d: got agent %0d gap %0d expected agent %0d gap 3",
                 g, idx, at - prev, exp_ord[g]);
      end
      prev = at;
    end
    tick(); tick(); tick();
    // Agent 0 arriving while 2 waits must be served before 2.
    agent_req = 3'b110;
    wait_gnt(idx, at);
    agent_req[1] = 1'b0;
    agent_req[0] = 1'b1;
    n_checks++;
    if (idx !== 1) begin
      n_fail++;
      $display("FAIL preempt_first: got %0d expected 1", idx);
    end
    wait_gnt(idx, at);
    agent_req[0] = 1'b0;
    n_checks++;
    if (idx !== 0) begin
      n_fail++;
      $display("FAIL preempt_agent0: got %0d expected 0", idx);
    end
    wait_gnt(idx, at);
    agent_req[2] = 1'b0;
    n_checks++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL preempt_last: got %0d expected 2", idx);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_rr_fairness();
    int idx, at, prev, exp_idx;
    agent_req = 3'b110;
    prev = 0;
    for (int g = 0; g < 8; g++) begin
      wait_gnt(idx, at);
      if (g == 7) agent_req = 3'b000;
`ifdef SYN_SRAM_ARB_RR_EN
      exp_idx = (g % 2 == 0) ? 1 : 2;
`else
      exp_idx = 1;
`endif
      n_checks++;
      if (idx !== exp_idx || (g > 0 && at - prev !== 3)) begin
        n_fail++;
        $display("FAIL fair_g%0d: got agent %0d gap %0d expected agent %0d gap 3",
                 g, idx, at - prev, exp_idx);
      end
      prev = at;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_read();
    int idx, at;
    logic [N-1:0] seen;
    set_agent(1, 1'b0, 18'h00010, 16'h0, 2'b11);
    agent_req[1] = 1'b1;
    wait_gnt(idx, at);
    agent_req[1] = 1'b0;
    tick();
    n_checks++;
    if (idx !== 1 || sram_oe_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_setup: got agent %0d oe_n=%b expected 1 0", idx, sram_oe_n);
    end
    rst_ih = 1'b1;
    tick();
    n_checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111 ||
        agent_rd_valid !== 3'b000 || sram_addr !== 18'h0 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got strb=%b rdv=%b addr=%h data=%h expected 11111 000 0 0",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, agent_rd_valid,
               sram_addr, rd_data);
    end
    rst_ih = 1'b0;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      seen = seen | agent_rd_valid;
    end
    n_checks++;
    if (seen !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_no_rdv: got %b expected 000", seen);
    end
    set_agent(2, 1'b0, 18'h3FFFF, 16'h0, 2'b11);
    agent_req[2] = 1'b1;
    wait_gnt(idx, at);
    agent_req[2] = 1'b0;
    tick(); tick();
    n_checks++;
    if (idx !== 2 || agent_rd_valid !== 3'b100 || rd_data !== 16'h12CD) begin
      n_fail++;
      $display("FAIL rst_after_read: got agent %0d rdv=%b data=%h expected 2 100 12cd",
               idx, agent_rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_turnaround();
    int idx, at, t1, c0, o0;
    mem[18'h00020] = 16'h0000;
    c0 = contention;
    o0 = oe_low;
    set_agent(1, 1'b1, 18'h00020, 16'h5A5A, 2'b11);
    set_agent(2, 1'b0, 18'h00020, 16'h0, 2'b11);
    agent_req = 3'b110;
    wait_gnt(idx, t1);
    agent_req[1] = 1'b0;
    n_checks++;
    if (idx !== 1) begin
      n_fail++;
      $display("FAIL ta_write_first: got %0d expected 1", idx);
    end
    wait_gnt(idx, at);
    agent_req[2] = 1'b0;
    n_checks++;
    if (idx !== 2 || at - t1 !== 3) begin
      n_fail++;
      $display("FAIL ta_read_next: got agent %0d gap %0d expected 2 gap 3", idx, at - t1);
    end
    tick(); tick();
    n_checks++;
    if (agent_rd_valid !== 3'b100 || rd_data !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL ta_readback: got rdv=%b data=%h expected 100 5a5a", agent_rd_valid, rd_data);
    end
    tick();
    n_checks++;
    if (contention - c0 !== 0 || oe_low - o0 !== 2) begin
      n_fail++;
      $display("FAIL ta_bus_contention: got overlap=%0d oe_low=%0d expected 0 2",
               contention - c0, oe_low - o0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_priority();
    test_rr_fairness();
    test_reset_mid_read();
    test_turnaround();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
